// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory controller bus between a CPU
// and a DMA/loader requester, one complete transaction at a time.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    state_t state;
    logic   last_grant;
    logic   we_q;
    logic   pick1;

    // On a tie the requester that did not win last time gets the bus.
    always_comb begin
        pick1 = req1 && (!req0 || !last_grant);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            we_q        <= 1'b0;
            grant       <= 2'b00;
            busy        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            rdata       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant       <= pick1 ? 2'b10 : 2'b01;
                        mem_address <= pick1 ? addr1 : addr0;
                        mem_data_in <= pick1 ? wdata1 : wdata0;
                        we_q        <= pick1 ? we1 : we0;
                        mem_we      <= pick1 ? we1 : we0;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata <= mem_data_out;
                    end
                    mem_we <= 1'b0;
                    ack0   <= grant[0];
                    ack1   <= grant[1];
                    state  <= RESPOND;
                end
                RESPOND: begin
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    last_grant <= grant[1];
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue expected transactions,
// a negedge monitor checks bus, arbitration order, acks and read data.
module tb_mem_arbiter;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        rq [2];
    logic        wq [2];
    logic [15:0] aq [2];
    logic [31:0] dq [2];
    logic        ack0, ack1;
    logic [31:0] rdata;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:65535];
    logic [31:0] refm [logic [15:0]];
    exp_t        q0 [$];
    exp_t        q1 [$];

    int          compared;
    int          mismatched;
    logic [31:0] exp_rdata;
    logic        last_served;
    logic        sreq0, sreq1;
    logic        prev_acc, prev_busy;
    logic        acc, rsp, eo, have;
    exp_t        me;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (rq[0]),
        .we0          (wq[0]),
        .addr0        (aq[0]),
        .wdata0       (dq[0]),
        .ack0         (ack0),
        .req1         (rq[1]),
        .we1          (wq[1]),
        .addr1        (aq[1]),
        .wdata1       (dq[1]),
        .ack1         (ack1),
        .rdata        (rdata),
        .grant        (grant),
        .busy         (busy),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory controller model: combinational read, write on the edge ending ACCESS.
    assign mem_data_out = mem[mem_address];
    always @(posedge clock) begin
        if (mem_we) mem[mem_address] <= mem_data_in;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the ack cycle.
    task automatic do_txn(input int r, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input bit keep);
        exp_t e;
        bit   got;
        e.we   = w;
        e.addr = a;
        e.data = d;
        e.rd   = refm.exists(a) ? refm[a] : 32'h0;
        if (r == 0) q0.push_back(e);
        else        q1.push_back(e);
        rq[r] = 1'b1;
        wq[r] = w;
        aq[r] = a;
        dq[r] = d;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clock);
            if ((r == 0) ? ack0 : ack1) got = 1'b1;
        end
        if (!got) chk($sformatf("ack%0d_timeout", r), 64'(got), 64'd1);
        @(posedge clock);
        #1;
        if (got && w) refm[a] = d;
        if (!keep) rq[r] = 1'b0;
    endtask

    task automatic rand_run(input int r, input int n);
        bit          keep;
        int          g;
        logic [15:0] base;
        keep = 1'b0;
        base = (r == 0) ? 16'h0800 : 16'h0100;
        for (int i = 0; i < n; i++) begin
            g = keep ? 0 : int'($urandom_range(0, 3));
            if (g > 0) begin
                repeat (g) @(posedge clock);
                #1;
            end
            keep = (i != n - 1) && ($urandom_range(0, 1) == 1);
            do_txn(r, 1'($urandom_range(0, 1)),
                   base + 16'($urandom_range(0, 3)), $urandom, keep);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            exp_rdata   = 32'h0;
            last_served = 1'b1;
            prev_acc    = 1'b0;
            prev_busy   = 1'b0;
            sreq0       = 1'b0;
            sreq1       = 1'b0;
        end else begin
            acc = busy && !ack0 && !ack1;
            rsp = ack0 || ack1;
            if (acc) begin
                eo   = (sreq0 && sreq1) ? !last_served : sreq1;
                have = eo ? (q1.size() > 0) : (q0.size() > 0);
                chk("access_after_idle", 64'(prev_busy), 64'd0);
                chk("grant_owner", 64'(grant), eo ? 64'd2 : 64'd1);
                chk("access_pending", 64'(have), 64'd1);
                if (have) begin
                    me = eo ? q1[0] : q0[0];
                    chk("mem_address", 64'(mem_address), 64'(me.addr));
                    chk("mem_we", 64'(mem_we), 64'(me.we));
                    if (me.we) chk("mem_data_in", 64'(mem_data_in), 64'(me.data));
                end
            end
            if (rsp) begin
                eo   = ack1;
                have = eo ? (q1.size() > 0) : (q0.size() > 0);
                chk("respond_after_access", 64'(prev_acc), 64'd1);
                chk("respond_grant", 64'(grant), eo ? 64'd2 : 64'd1);
                chk("respond_pending", 64'(have), 64'd1);
                if (have) begin
                    me = eo ? q1.pop_front() : q0.pop_front();
                    if (!me.we) exp_rdata = me.rd;
                end
                last_served = eo;
            end
            chk("invariant", 64'(!(ack0 && ack1) && grant != 2'b11 &&
                                 !(mem_we && grant == 2'b00) &&
                                 (acc || !mem_we) &&
                                 (busy || grant == 2'b00)), 64'd1);
            chk("rdata", 64'(rdata), 64'(exp_rdata));
            if (!busy) begin
                sreq0 = rq[0];
                sreq1 = rq[1];
            end
            prev_acc  = acc;
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int r = 0; r < 2; r++) begin
            rq[r] = 1'b0;
            wq[r] = 1'b0;
            aq[r] = 16'h0;
            dq[r] = 32'h0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_mem_we", 64'(mem_we), 64'd0);
        chk("reset_outputs", 64'({ack0, ack1, busy, mem_address, mem_data_in, rdata}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_quiet", 64'({grant, mem_we, ack0, ack1, busy}), 64'd0);
            chk("idle_rdata", 64'(rdata), 64'd0);
        end
        @(posedge clock);
        #1;

        do_txn(0, 1'b1, 16'h0800, 32'hDEADBEEF, 1'b0);
        do_txn(0, 1'b0, 16'h0800, 32'h0, 1'b0);
        chk("read_back", 64'(rdata), 64'hDEADBEEF);

        fork
            for (int i = 0; i < 4; i++)
                do_txn(0, 1'b0, 16'h0800 + 16'(i), 32'h0, i != 3);
            for (int i = 0; i < 4; i++)
                do_txn(1, 1'b1, 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i), i != 3);
        join

        for (int i = 0; i < 3; i++)
            do_txn(1, 1'b0, 16'h0100 + 16'(i), 32'h0, i != 2);

        fork
            do_txn(0, 1'b1, 16'h0802, 32'h1234_5678, 1'b0);
            begin
                @(posedge clock);
                #1;
                do_txn(1, 1'b0, 16'h0101, 32'h0, 1'b0);
            end
        join

        fork
            rand_run(0, 25);
            rand_run(1, 25);
        join

        repeat (2) @(posedge clock);
        #1;
        q0.push_back('{we: 1'b1, addr: 16'h0801, data: 32'hCAFE_F00D, rd: 32'h0});
        rq[0] = 1'b1;
        wq[0] = 1'b1;
        aq[0] = 16'h0801;
        dq[0] = 32'hCAFE_F00D;
        @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
        rq[0] = 1'b0;
        #1;
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_grant", 64'(grant), 64'd0);
        chk("abort_ack", 64'({ack0, ack1, busy}), 64'd0);
        @(negedge clock);
        chk("abort_no_ack", 64'({ack0, ack1}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        fork
            do_txn(0, 1'b0, 16'h0801, 32'h0, 1'b0);
            do_txn(1, 1'b0, 16'h0102, 32'h0, 1'b0);
        join

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
